addr_decode_napot_table: RTL and testbench
==========================================

// Module: addr_decode_napot_table
// PURPOSE
//  Runtime-programmable NAPOT address decoder with a registered, valid/ready-handshaked result stage.
//  Holds NoRules rules in an active table plus a shadow table. Software writes the shadow; a commit copies it atomically.
//  Sits in front of crossbar/demux routing where the address map changes at runtime (e.g. PMP-like windows, hot-plugged slaves).
//  Adds per-rule enable and multi-hit reporting.
// PARAMETERS
//  NoIndices  32'd0  highest port index + 1; rule idx must be < NoIndices
//  NoRules    32'd0  number of table entries (>=1)
//  addr_t     logic  address type
//  rule_t     logic  packed struct {int unsigned idx; addr_t base; addr_t mask;}
//  IdxWidth   cf_math_pkg::idx_width(NoIndices)  dependent, do not override
//  idx_t      logic [IdxWidth-1:0]  dependent, do not override
// PORTS
//  clk_i             in   1         clock
//  rst_ni            in   1         asynchronous reset, active-low
//  req_valid_i       in   1         decode request valid
//  req_ready_o       out  1         decode request accepted when valid&ready
//  req_addr_i        in   addr_t    address to decode
//  rsp_valid_o       out  1         result valid
//  rsp_ready_i       in   1         result consumed when valid&ready
//  rsp_idx_o         out  idx_t     decoded index (or default index)
//  rsp_dec_valid_o   out  1         a rule, or the default, matched
//  rsp_dec_error_o   out  1         no enabled rule matched and default disabled
//  rsp_multi_hit_o   out  1         >=2 enabled rules matched
//  en_default_idx_i  in   1         enable default mapping; tie 0 if unused
//  default_idx_i     in   idx_t     default index; tie 0 if unused
//  cfg_we_i          in   1         write shadow entry cfg_sel_i
//  cfg_sel_i         in   $clog2(NoRules) (min 1)  shadow entry select
//  cfg_rule_i        in   rule_t    shadow rule data
//  cfg_en_i          in   1         shadow entry enable
//  cfg_commit_i      in   1         copy whole shadow table to active table
//  cfg_busy_o        out  1         commit pending (waiting for drain)
// BEHAVIOUR
//  - Reset: both tables zero, all enables 0, cfg_busy_o=0, rsp_valid_o=0. Result fields 0: idx, dec_valid, dec_error, multi_hit.
//  - Match for entry i: en[i] & ((req_addr_i & mask) == (base & mask)). mask=0 matches every address.
//  - Priority: the highest matching entry number wins. rsp_idx_o = rule.idx[IdxWidth-1:0].
//  - No match: if en_default_idx_i=1, idx=default_idx_i, dec_valid=1, dec_error=0.
//    Otherwise idx=0, dec_valid=0, dec_error=1.
//  - rsp_multi_hit_o is set when the popcount of matches is >=2. It is informational only; dec_valid is unchanged.
//  - Decoding is combinational from req_addr_i and the active table. The result is captured in a single output register.
//  - Latency is 1 cycle: a request accepted in cycle N gives rsp_valid_o=1 in cycle N+1.
//  - req_ready_o = ~rsp_valid_o | rsp_ready_i when no commit is blocking. This gives full throughput with no bubbles.
//  - Output is held stable while rsp_valid_o & ~rsp_ready_i (AXI-style). It never changes without a handshake.
//  - cfg_we_i writes shadow[cfg_sel_i] in the same cycle. It never affects the active table directly.
//  - A cfg_sel_i value >= NoRules is ignored; an assertion flags it.
//  - Commit FSM states:
//    - IDLE: on cfg_commit_i, go to DRAIN and assert cfg_busy_o.
//    - DRAIN: req_ready_o=0; wait until rsp_valid_o=0, or a rsp handshake this cycle empties the stage. Then go to COPY.
//    - COPY: one cycle, active<=shadow; return to IDLE with cfg_busy_o=0. Requests accepted from the next cycle use the new table.
//  - In IDLE, cfg_commit_i is honoured even in the same cycle as a request handshake. That request uses the old table.
//  - cfg_commit_i in DRAIN or COPY is ignored; the commit already in flight carries the latest shadow.
//  - cfg_we_i in the COPY cycle: the write to shadow is seen by the copy (write-first). The new value lands in active.
//  - en_default_idx_i/default_idx_i are sampled at request acceptance, not at commit.
//  - Async reset mid-operation: the result stage and FSM clear immediately and any pending commit is lost. Tables clear to zero.
//  - Assertions: NoRules>0; committed rule.idx < NoIndices; handshake stability on rsp_* while valid&~ready.
// TESTING
//  - Reset, no config: req addr 0x1000, default off -> 1 cycle later rsp_dec_error=1, idx=0.
//    Same with default on, default_idx=3 -> rsp_idx=3, dec_valid=1.
//  - Program e0{idx1,base 0x0000_0000,mask 0xFFFF_0000,en}, e1{idx2,base 0x0001_0000,mask 0xFFFF_0000,en}, then commit:
//    - addr 0x0001_0040 -> idx 2, multi_hit 0;
//    - addr 0x0000_0040 -> idx 1.
//  - Overlap: e2{idx5,mask 0,en} committed; addr 0x0000_0040 -> idx 5, multi_hit=1 (e0 and e2 hit).
//  - Backpressure: rsp_ready_i=0 for 4 cycles after the first result -> req_ready_o=0 and rsp_* stable.
//    Release -> back-to-back results, one per cycle, for 8 requests.
//  - Commit with a stalled output: commit while rsp_valid=1, ready=0 -> cfg_busy=1, req_ready=0.
//    Release ready -> one COPY cycle, then the next request decodes with the new table. No request mixes tables.
//  - Shadow isolation: write shadow e0 idx 7 without commit -> decodes still return idx 1. After commit -> 7.
//    Reset asserted during DRAIN -> active table zeroed, busy=0.

Source files
------------

// File: rtl/addr_decode_napot_table.sv
// Runtime-programmable NAPOT address decoder.
// A shadow rule table is written by software and copied atomically into the
// active table on commit, once the registered result stage has drained.
// The decode result is held in a single valid/ready output register.
module addr_decode_napot_table #(
    parameter int unsigned NoIndices = 32'd0,
    parameter int unsigned NoRules   = 32'd0,
    parameter type         addr_t    = logic [31:0],
    // Packed layout {int unsigned idx; addr_t base; addr_t mask;}
    parameter type         rule_t    = logic [95:0],
    parameter int unsigned IdxWidth  = (NoIndices > 32'd1) ? $clog2(NoIndices) : 32'd1,
    parameter type         idx_t     = logic [IdxWidth-1:0]
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  req_valid_i,
    output logic  req_ready_o,
    input  addr_t req_addr_i,
    output logic  rsp_valid_o,
    input  logic  rsp_ready_i,
    output idx_t  rsp_idx_o,
    output logic  rsp_dec_valid_o,
    output logic  rsp_dec_error_o,
    output logic  rsp_multi_hit_o,
    input  logic  en_default_idx_i,
    input  idx_t  default_idx_i,
    input  logic  cfg_we_i,
    input  logic [((NoRules > 32'd1) ? $clog2(NoRules) : 1)-1:0] cfg_sel_i,
    input  rule_t cfg_rule_i,
    input  logic  cfg_en_i,
    input  logic  cfg_commit_i,
    output logic  cfg_busy_o
);

    // A zero-rule instance still elaborates with one (never enabled) entry.
    localparam int unsigned NR     = (NoRules > 32'd0) ? NoRules : 32'd1;
    localparam int unsigned SelW   = (NoRules > 32'd1) ? $clog2(NoRules) : 1;
    localparam int unsigned AW     = $bits(addr_t);
    localparam int unsigned RW     = $bits(rule_t);
    localparam int unsigned IdxOff = 2 * AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COPY
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;

    logic [RW-1:0]   r_shadow     [NR];
    logic [NR-1:0]   r_shadow_en;
    logic [RW-1:0]   r_active     [NR];
    logic [NR-1:0]   r_active_en;
    logic [RW-1:0]   w_shadow_nxt [NR];
    logic [NR-1:0]   w_shadow_en_nxt;

    logic            r_rsp_valid;
    idx_t            r_rsp_idx;
    logic            r_rsp_dec_valid;
    logic            r_rsp_dec_error;
    logic            r_rsp_multi_hit;

    logic            w_req_hs;
    logic            w_rsp_hs;
    logic            w_copy;
    logic            w_hit_any;
    logic            w_multi;
    idx_t            w_hit_idx;
    idx_t            w_dec_idx;
    logic            w_dec_valid;
    logic            w_dec_error;
    logic [RW-1:0]   w_cfg_bits;

    assign w_cfg_bits = cfg_rule_i;

    // Requests are only accepted while no commit is in flight.
    assign req_ready_o = (r_state == ST_IDLE) && (!r_rsp_valid || rsp_ready_i);
    assign w_req_hs    = req_valid_i && req_ready_o;
    assign w_rsp_hs    = r_rsp_valid && rsp_ready_i;
    assign w_copy      = (r_state == ST_COPY);
    assign cfg_busy_o  = (r_state != ST_IDLE);

    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_idx_o       = r_rsp_idx;
    assign rsp_dec_valid_o = r_rsp_dec_valid;
    assign rsp_dec_error_o = r_rsp_dec_error;
    assign rsp_multi_hit_o = r_rsp_multi_hit;

    // Shadow table with this cycle's write applied (write-first view for the copy).
    always_comb begin
        w_shadow_nxt    = r_shadow;
        w_shadow_en_nxt = r_shadow_en;
        for (int i = 0; i < NR; i++) begin
            if (cfg_we_i && (cfg_sel_i == SelW'(i))) begin
                w_shadow_nxt[i]    = w_cfg_bits;
                w_shadow_en_nxt[i] = cfg_en_i;
            end
        end
    end

    // Match every active entry; later entries override, so the highest one wins.
    always_comb begin
        w_hit_any = 1'b0;
        w_multi   = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < NR; i++) begin
            if (r_active_en[i] &&
                ((req_addr_i & r_active[i][AW-1:0]) ==
                 (r_active[i][2*AW-1:AW] & r_active[i][AW-1:0]))) begin
                if (w_hit_any) begin
                    w_multi = 1'b1;
                end
                w_hit_any = 1'b1;
                w_hit_idx = r_active[i][IdxOff +: IdxWidth];
            end
        end
    end

    // Resolve the final index, falling back to the default mapping or an error.
    always_comb begin
        w_dec_idx   = '0;
        w_dec_valid = 1'b0;
        w_dec_error = 1'b0;
        if (w_hit_any) begin
            w_dec_idx   = w_hit_idx;
            w_dec_valid = 1'b1;
        end else if (en_default_idx_i) begin
            w_dec_idx   = default_idx_i;
            w_dec_valid = 1'b1;
        end else begin
            w_dec_error = 1'b1;
        end
    end

    // Commit FSM next state: wait for the result stage to empty, then copy once.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_commit_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_rsp_valid || w_rsp_hs) begin
                    w_state_nxt = ST_COPY;
                end
            end
            ST_COPY: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Commit FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shadow and active rule tables; active only changes in the COPY cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_shadow_en <= '0;
            r_active_en <= '0;
        end else begin
            r_shadow    <= w_shadow_nxt;
            r_shadow_en <= w_shadow_en_nxt;
            if (w_copy) begin
                r_active    <= w_shadow_nxt;
                r_active_en <= w_shadow_en_nxt;
            end
        end
    end

    // Result register: load on accept, otherwise hold until consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid     <= 1'b0;
            r_rsp_idx       <= '0;
            r_rsp_dec_valid <= 1'b0;
            r_rsp_dec_error <= 1'b0;
            r_rsp_multi_hit <= 1'b0;
        end else if (w_req_hs) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_idx       <= w_dec_idx;
            r_rsp_dec_valid <= w_dec_valid;
            r_rsp_dec_error <= w_dec_error;
            r_rsp_multi_hit <= w_multi;
        end else if (w_rsp_hs) begin
            r_rsp_valid     <= 1'b0;
        end
    end

    a_no_rules : assert property (@(posedge clk_i) NoRules > 32'd0)
        else $error("addr_decode_napot_table: NoRules must be at least 1");

    a_sel_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        cfg_we_i |-> (32'(cfg_sel_i) < NoRules))
        else $error("addr_decode_napot_table: cfg_sel_i out of range, write ignored");

    a_rsp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_o && !rsp_ready_i) |=>
        (rsp_valid_o && $stable(rsp_idx_o) && $stable(rsp_dec_valid_o) &&
         $stable(rsp_dec_error_o) && $stable(rsp_multi_hit_o)))
        else $error("addr_decode_napot_table: rsp changed while stalled");

    for (genvar g = 0; g < NR; g++) begin : g_idx_chk
        a_idx_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (w_copy && w_shadow_en_nxt[g]) |-> (w_shadow_nxt[g][IdxOff +: 32] < NoIndices))
            else $error("addr_decode_napot_table: committed rule idx >= NoIndices");
    end

endmodule

// File: tb/tb_addr_decode_napot_table.sv
// Directed bench for addr_decode_napot_table (8 indices, 4 rules, 32-bit addresses).
module tb_addr_decode_napot_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [2:0]  rsp_idx;
    logic        rsp_dv;
    logic        rsp_err;
    logic        rsp_mh;
    logic        en_def = 1'b0;
    logic [2:0]  def_idx = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = '0;
    logic [95:0] cfg_rule = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_commit = 1'b0;
    logic        busy;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    addr_decode_napot_table #(
        .NoIndices (32'd8),
        .NoRules   (32'd4)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_addr_i       (req_addr),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_idx_o        (rsp_idx),
        .rsp_dec_valid_o  (rsp_dv),
        .rsp_dec_error_o  (rsp_err),
        .rsp_multi_hit_o  (rsp_mh),
        .en_default_idx_i (en_def),
        .default_idx_i    (def_idx),
        .cfg_we_i         (cfg_we),
        .cfg_sel_i        (cfg_sel),
        .cfg_rule_i       (cfg_rule),
        .cfg_en_i         (cfg_en),
        .cfg_commit_i     (cfg_commit),
        .cfg_busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic wr(input logic [1:0] sel, input logic [31:0] idx,
                      input logic [31:0] base, input logic [31:0] mask, input logic en);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_rule = {idx, base, mask};
        cfg_en   = en;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic commit(input string tag);
        int k;
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        k = 0;
        while (busy === 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    // Single request with rsp_ready high; checks the result one cycle later.
    task automatic req(input string tag, input logic [31:0] addr, input logic [31:0] eidx,
                       input logic edv, input logic eerr, input logic emh);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        chk({tag, "_rdy"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_idx"}, rsp_idx, eidx);
        chk({tag, "_dv"},  rsp_dv,  edv);
        chk({tag, "_err"}, rsp_err, eerr);
        chk({tag, "_mh"},  rsp_mh,  emh);
    endtask

    logic [31:0] sa [8] = '{32'h0000_0040, 32'h0001_0040, 32'h0002_0000, 32'h0000_FFFF,
                            32'h0001_FFFF, 32'h0000_0000, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] si [8] = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd1, 32'd2, 32'd0};
    logic        se [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_vld",  rsp_valid, 0);
        chk("rst_idx",  rsp_idx, 0);
        chk("rst_dv",   rsp_dv, 0);
        chk("rst_err",  rsp_err, 0);
        chk("rst_mh",   rsp_mh, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty table: error, then default mapping
        req("nocfg", 32'h0000_1000, 0, 0, 1, 0);
        en_def  = 1'b1;
        def_idx = 3'd3;
        req("dflt", 32'h0000_1000, 3, 1, 0, 0);
        en_def  = 1'b0;

        // Two disjoint windows
        wr(2'd0, 32'd1, 32'h0000_0000, 32'hFFFF_0000, 1'b1);
        wr(2'd1, 32'd2, 32'h0001_0000, 32'hFFFF_0000, 1'b1);
        commit("c1");
        req("win1", 32'h0001_0040, 2, 1, 0, 0);
        req("win0", 32'h0000_0040, 1, 1, 0, 0);

        // Overlap with a catch-all; a disabled higher entry must not win
        wr(2'd2, 32'd5, 32'h0000_0000, 32'h0000_0000, 1'b1);
        wr(2'd3, 32'd6, 32'h0000_0000, 32'h0000_0000, 1'b0);
        commit("c2");
        req("ovl0", 32'h0000_0040, 5, 1, 0, 1);
        req("ovl1", 32'h0001_0040, 5, 1, 0, 1);

        // Drop the catch-all again
        wr(2'd2, 32'd5, 32'h0000_0000, 32'h0000_0000, 1'b0);
        commit("c3");

        // Backpressure: stall for 4 cycles, then 8 back-to-back results
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        #1;
        chk("bp_rdy0", req_ready, 1);
        @(negedge clk);
        req_addr = sa[0];
        for (int s = 0; s < 4; s++) begin
            #1;
            chk("bp_vld", rsp_valid, 1);
            chk("bp_idx", rsp_idx, 1);
            chk("bp_rdy", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", req_ready, 1);
        chk("bp_rel_idx", rsp_idx, 1);
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            if (j < 7) req_addr = sa[j+1];
            else req_valid = 1'b0;
            #1;
            chk("st_vld", rsp_valid, 1);
            chk("st_idx", rsp_idx, si[j]);
            chk("st_err", rsp_err, se[j]);
            @(negedge clk);
        end
        #1;
        chk("st_empty", rsp_valid, 0);

        // Commit while the output is stalled
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("cs_vld", rsp_valid, 1);
        chk("cs_idx", rsp_idx, 1);
        wr(2'd3, 32'd4, 32'h0000_0040, 32'hFFFF_FFFF, 1'b1);
        cfg_commit = 1'b1;
        #1;
        chk("cs_rdy_stall", req_ready, 0);
        @(negedge clk);
        cfg_commit = 1'b0;
        req_valid  = 1'b1;
        #1;
        chk("cs_busy_d", busy, 1);
        chk("cs_rdy_d", req_ready, 0);
        chk("cs_hold_idx", rsp_idx, 1);
        @(negedge clk);
        chk("cs_busy_d2", busy, 1);
        rsp_ready = 1'b1;
        #1;
        chk("cs_rdy_drain", req_ready, 0);
        @(negedge clk);
        chk("cs_busy_copy", busy, 1);
        chk("cs_vld_copy", rsp_valid, 0);
        chk("cs_rdy_copy", req_ready, 0);
        @(negedge clk);
        chk("cs_busy_idle", busy, 0);
        chk("cs_rdy_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("cs_new_vld", rsp_valid, 1);
        chk("cs_new_idx", rsp_idx, 4);
        chk("cs_new_mh", rsp_mh, 1);
        @(negedge clk);

        // Shadow isolation
        wr(2'd0, 32'd7, 32'h0000_0000, 32'hFFFF_0000, 1'b1);
        req("iso_old", 32'h0000_0080, 1, 1, 0, 0);
        commit("c4");
        req("iso_new", 32'h0000_0080, 7, 1, 0, 0);
        req("iso_pri", 32'h0000_0040, 4, 1, 0, 1);

        // Reset while a commit is draining
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0080;
        @(negedge clk);
        req_valid  = 1'b0;
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        #1;
        chk("rd_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rd_busy_clr", busy, 0);
        chk("rd_vld_clr", rsp_valid, 0);
        chk("rd_idx_clr", rsp_idx, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        req("rd_act_zero", 32'h0000_0080, 0, 0, 1, 0);
        @(negedge clk);
        commit("c5");
        req("rd_sh_zero", 32'h0000_0080, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
